tpu_seq_ctrl: RTL and testbench
===============================

TPU_SEQ_CTRL -- requirements
Module: tpu_seq_ctrl

Interface
REQ-001 Parameter ADDRESSSIZE, default 10, SHALL be the SRAM address width.
REQ-002 Parameter MATRIX_SIZE, default 8, SHALL be the systolic array column count.
REQ-003 Parameter NUM_PE_ROWS, default 8, SHALL be the systolic array row count.
REQ-004 Parameter DRAIN_CYCLES, default MATRIX_SIZE+NUM_PE_ROWS-1 (15), SHALL be the post-stream pipeline flush length; legal range is 1 or more.
REQ-005 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-006 rstn  in  1  SHALL be the asynchronous, active-low reset.
REQ-007 start  in  1  SHALL request one job (sampled only in IDLE).
REQ-008 abort  in  1  SHALL be a synchronous job cancel.
REQ-009 base_addr  in  ADDRESSSIZE  SHALL be the first input-vector SRAM address, latched at start.
REQ-010 num_vectors  in  ADDRESSSIZE+1  SHALL be the input-vector count, latched at start.
REQ-011 fifo_empty  in  1  SHALL be the weight FIFO empty flag.
REQ-012 fifo_read_enable  out  1  SHALL pop one weight-FIFO row.
REQ-013 we_rl  out  1  SHALL load the popped weight row into the PE array.
REQ-014 valid_address  out  1  SHALL mark sram_address as a live read.
REQ-015 sram_address  out  ADDRESSSIZE  SHALL be the SRAM read address.
REQ-016 busy  out  1  SHALL be high in every state except IDLE.
REQ-017 end_  out  1  SHALL be a one-cycle job-complete pulse.

Function
REQ-018 The FSM SHALL have states IDLE, FETCH_W, LOAD_W, STREAM, DRAIN, DONE, held in a registered state variable.
REQ-019 In IDLE, start=1 SHALL latch base_addr/num_vectors and move to FETCH_W; start in any other state SHALL be ignored.
REQ-020 In FETCH_W, fifo_read_enable SHALL equal !fifo_empty (combinational); the state SHALL hold while fifo_empty=1 and go to LOAD_W on the cycle fifo_empty=0.
REQ-021 LOAD_W SHALL last exactly one cycle with we_rl=1, then go to STREAM, or to DONE if the latched num_vectors=0.
REQ-022 In STREAM, valid_address=1 and sram_address=(base+idx) mod 2^ADDRESSSIZE, idx counting 0..num_vectors-1, one address per cycle, then DRAIN.
REQ-023 DRAIN SHALL last exactly DRAIN_CYCLES cycles with all strobes low, then DONE.
REQ-024 DONE SHALL last one cycle with end_=1, then IDLE; a start in the following IDLE cycle SHALL be accepted.
REQ-025 Outside their owning states fifo_read_enable, we_rl, valid_address and end_ SHALL be 0; sram_address SHALL be 0 when valid_address=0.
REQ-026 Address arithmetic SHALL wrap modulo 2^ADDRESSSIZE without flags; num_vectors up to 2^ADDRESSSIZE SHALL be honoured.
REQ-027 abort=1 in any non-IDLE state SHALL force IDLE at the next edge, with no end_ pulse; abort has priority over all transitions; abort in IDLE SHALL be ignored and SHALL also override a simultaneous start.
REQ-028 Latency with a non-empty FIFO: start sampled at edge N puts FETCH_W in cycle N+1, LOAD_W in N+2, STREAM in N+3..N+2+V, DRAIN for D cycles, and end_ in cycle N+3+V+D.

Reset
REQ-029 rstn=0 SHALL immediately force IDLE, clear idx, drain counter and latched fields, and drive every output to 0, including mid-job.
REQ-030 After rstn deasserts, the block SHALL wait for a fresh start; a start held through reset release SHALL be sampled on the first edge.

Verification
REQ-031 base=0, V=16, FIFO non-empty, start pulse -> one fifo_read_enable, one we_rl, addresses 0..15 on consecutive cycles, end_ exactly 34 cycles after the start edge.
REQ-032 fifo_empty=1 for 5 cycles after start -> FETCH_W holds 5 cycles with fifo_read_enable=0, then pops once; end_ is delayed by 5 cycles.
REQ-033 base=1020, V=8 -> addresses 1020..1023,0..3, with no other change.
REQ-034 V=0 -> pop and we_rl occur, valid_address never asserts, end_ appears in the cycle after LOAD_W.
REQ-035 abort during STREAM at idx=5 -> IDLE next cycle, no end_, busy=0; a subsequent start runs a full job.
REQ-036 rstn pulsed low during DRAIN -> all outputs 0 asynchronously; start during busy is ignored, with no second pop.

Source files
------------

// File: rtl/tpu_seq_ctrl.sv
// Sequencer for one systolic-array job.
// Flow: pop a weight row, load it into the PE array, stream the input-vector
// read addresses, flush the array pipeline, then pulse end_.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for start; base/count latched on acceptance
// FETCH_W | pop one weight row as soon as the FIFO is non-empty
// LOAD_W  | one cycle: write the popped row into the PE array
// STREAM  | one SRAM read address per cycle, idx = 0 .. num_vectors-1
// DRAIN   | DRAIN_CYCLES quiet cycles to flush the array pipeline
// DONE    | one cycle: end_ pulse
module tpu_seq_ctrl #(
  parameter int ADDRESSSIZE  = 10,
  parameter int MATRIX_SIZE  = 8,
  parameter int NUM_PE_ROWS  = 8,
  parameter int DRAIN_CYCLES = MATRIX_SIZE + NUM_PE_ROWS - 1
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   start,
  input  logic                   abort,
  input  logic [ADDRESSSIZE-1:0] base_addr,
  input  logic [ADDRESSSIZE:0]   num_vectors,
  input  logic                   fifo_empty,
  output logic                   fifo_read_enable,
  output logic                   we_rl,
  output logic                   valid_address,
  output logic [ADDRESSSIZE-1:0] sram_address,
  output logic                   busy,
  output logic                   end_
);

  // Drain timer is a down-counter preloaded with DRAIN_CYCLES-1; terminal count 0.
  localparam int DCW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH_W = 3'd1,
    LOAD_W  = 3'd2,
    STREAM  = 3'd3,
    DRAIN   = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t                 state, state_nxt;
  logic [ADDRESSSIZE-1:0] base_q;
  logic [ADDRESSSIZE:0]   nv_q;
  logic [ADDRESSSIZE:0]   idx;
  logic [DCW-1:0]         drain_cnt;
  logic                   accept;
  logic                   last_vec;

  // Abort in IDLE is ignored, but it still blocks a start in the same cycle.
  assign accept   = (state == IDLE) && start && !abort;
  assign last_vec = (idx == (nv_q - (ADDRESSSIZE+1)'(1)));

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Job fields, vector index and drain timer.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      base_q    <= '0;
      nv_q      <= '0;
      idx       <= '0;
      drain_cnt <= '0;
    end else begin
      if (accept) begin
        base_q <= base_addr;
        nv_q   <= num_vectors;
      end
      if (state == STREAM) idx <= idx + (ADDRESSSIZE+1)'(1);
      else                 idx <= '0;
      if (state == DRAIN) drain_cnt <= drain_cnt - DCW'(1);
      else                drain_cnt <= DCW'(DRAIN_CYCLES - 1);
    end
  end

  // Next-state logic; abort overrides every transition out of a busy state.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = FETCH_W;
      FETCH_W: if (!fifo_empty) state_nxt = LOAD_W;
      LOAD_W:  state_nxt = (nv_q == '0) ? DONE : STREAM;
      STREAM:  if (last_vec) state_nxt = DRAIN;
      DRAIN:   if (drain_cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort && (state != IDLE)) state_nxt = IDLE;
  end

  // Output decode; the address bus is held at zero whenever it is not live.
  always_comb begin
    fifo_read_enable = 1'b0;
    we_rl            = 1'b0;
    valid_address    = 1'b0;
    sram_address     = '0;
    end_             = 1'b0;
    busy             = (state != IDLE);
    case (state)
      FETCH_W: fifo_read_enable = !fifo_empty;
      LOAD_W:  we_rl = 1'b1;
      STREAM: begin
        valid_address = 1'b1;
        sram_address  = base_q + idx[ADDRESSSIZE-1:0];
      end
      DONE:    end_ = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_tpu_seq_ctrl.sv
// Bench for tpu_seq_ctrl: table of whole jobs plus hand-written abort/reset sequences.
module tb_tpu_seq_ctrl;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rstn;
  logic          start;
  logic          abort;
  logic [AW-1:0] base_addr;
  logic [AW:0]   num_vectors;
  logic          fifo_empty;
  logic          fifo_read_enable;
  logic          we_rl;
  logic          valid_address;
  logic [AW-1:0] sram_address;
  logic          busy;
  logic          end_;

  int n_pass = 0;
  int n_tot  = 0;

  tpu_seq_ctrl dut (
    .clk              (clk),
    .rstn             (rstn),
    .start            (start),
    .abort            (abort),
    .base_addr        (base_addr),
    .num_vectors      (num_vectors),
    .fifo_empty       (fifo_empty),
    .fifo_read_enable (fifo_read_enable),
    .we_rl            (we_rl),
    .valid_address    (valid_address),
    .sram_address     (sram_address),
    .busy             (busy),
    .end_             (end_)
  );

  always #5 clk = ~clk;

  typedef struct {
    int base;
    int nv;
    int empty;      // cycles the FIFO stays empty after start
    bit hold;       // keep start asserted while busy
    int exp_end;    // cycle (after start edge) carrying end_
    int exp_pops;
    int exp_we;
    int exp_valid;
    int exp_first;
    int exp_last;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Called right after the edge that samples start; follows the job to end_.
  task automatic watch(input vec_t v, input int id);
    int pops = 0, wes = 0, vals = 0, aerr = 0, busyc = 0, endk = -1;
    int first = 0, last = 0;
    for (int k = 1; k <= 1200; k++) begin
      #1;
      start      = v.hold;
      fifo_empty = (k <= v.empty);
      #1;
      if (busy) busyc++;
      if (fifo_read_enable) pops++;
      if (we_rl) wes++;
      if (valid_address) begin
        if (int'(sram_address) != ((v.base + vals) % 1024)) aerr++;
        if (vals == 0) first = int'(sram_address);
        last = int'(sram_address);
        vals++;
      end else if (sram_address != '0) aerr++;
      if (end_) begin
        endk = k;
        break;
      end
      @(posedge clk);
    end
    start = 1'b0;
    chk($sformatf("v%0d pops", id), pops, v.exp_pops);
    chk($sformatf("v%0d we_rl", id), wes, v.exp_we);
    chk($sformatf("v%0d valid_cnt", id), vals, v.exp_valid);
    chk($sformatf("v%0d addr_err", id), aerr, 0);
    chk($sformatf("v%0d first_addr", id), first, v.exp_first);
    chk($sformatf("v%0d last_addr", id), last, v.exp_last);
    chk($sformatf("v%0d end_cycle", id), endk, v.exp_end);
    chk($sformatf("v%0d busy_cycles", id), busyc, v.exp_end);
    @(posedge clk); #2;
    chk($sformatf("v%0d busy_after", id), int'(busy), 0);
  endtask

  task automatic run_job(input vec_t v, input int id);
    base_addr   = AW'(v.base);
    num_vectors = (AW+1)'(v.nv);
    fifo_empty  = (v.empty > 0);
    start       = 1'b1;
    @(posedge clk);
    watch(v, id);
  endtask

  initial begin
    int ends;
    vec_t rv;
    //          base  nv    E  hold end   pops we valid first last
    vecs[0] = '{0,    16,   0, 0,   34,   1,   1, 16,   0,    15};
    vecs[1] = '{0,    16,   5, 0,   39,   1,   1, 16,   0,    15};
    vecs[2] = '{1020, 8,    0, 0,   26,   1,   1, 8,    1020, 3};
    vecs[3] = '{5,    0,    0, 0,   3,    1,   1, 0,    0,    0};
    vecs[4] = '{100,  1,    0, 1,   19,   1,   1, 1,    100,  100};
    vecs[5] = '{1023, 1024, 0, 0,   1042, 1,   1, 1024, 1023, 1022};

    rstn = 1'b0; start = 1'b0; abort = 1'b0; fifo_empty = 1'b0;
    base_addr = '0; num_vectors = '0;
    #23;
    chk("rst busy", int'(busy), 0);
    chk("rst outs", int'({fifo_read_enable, we_rl, valid_address, end_}), 0);
    chk("rst addr", int'(sram_address), 0);
    @(posedge clk); #1; rstn = 1'b1;
    @(posedge clk); #1;

    // Abort in IDLE overrides a simultaneous start.
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    #1 chk("idle abort+start busy", int'(busy), 0);

    for (int i = 0; i < 6; i++) run_job(vecs[i], i);

    // Abort while streaming idx 5.
    base_addr = '0; num_vectors = 11'd16; fifo_empty = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k < 8; k++) @(posedge clk);
    #2;
    chk("abort pre valid", int'(valid_address), 1);
    chk("abort pre addr", int'(sram_address), 5);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    #1;
    chk("abort busy", int'(busy), 0);
    chk("abort valid", int'(valid_address), 0);
    ends = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #2;
      if (end_) ends++;
    end
    chk("abort no end_", ends, 0);
    run_job(vecs[0], 10);

    // Reset during DRAIN, with start held through reset release.
    base_addr = 10'd7; num_vectors = 11'd4; fifo_empty = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k < 10; k++) @(posedge clk);
    #2 chk("drain busy", int'(busy), 1);
    #1 rstn = 1'b0;
    #1;
    chk("mid rst busy", int'(busy), 0);
    chk("mid rst outs", int'({fifo_read_enable, we_rl, valid_address, end_}), 0);
    chk("mid rst addr", int'(sram_address), 0);
    base_addr = 10'd50; num_vectors = 11'd2; start = 1'b1;
    @(posedge clk); #1;
    chk("rst start ignored", int'(busy), 0);
    rstn = 1'b1;
    @(posedge clk);
    rv = '{50, 2, 0, 0, 20, 1, 1, 2, 50, 51};
    watch(rv, 11);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
